// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

   localparam int unsigned DefaultWidth = 4;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

endpackage : serial_sub_pkg

// File: rtl/full_subtractor.sv
// One-bit combinational full-subtractor cell: diff = a - b - bin.
module full_subtractor (
   input  logic i_a,
   input  logic i_b,
   input  logic i_bin,
   output logic o_diff,
   output logic o_bout
);

   logic w_axb;

   assign w_axb  = i_a ^ i_b;
   assign o_diff = w_axb ^ i_bin;
   assign o_bout = (~i_a & i_b) | (~w_axb & i_bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, with start/ready/done framing.
// Define SUB_OVERFLOW_EN to add the registered signed-overflow output.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_bin,
   output logic             o_ready,
   output logic             o_done,
   output logic [WIDTH-1:0] o_diff,
   output logic             o_bout
`ifdef SUB_OVERFLOW_EN
   ,
   output logic             o_overflow
`endif
);

   localparam int unsigned CntW = $clog2(WIDTH) + 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   state_e           r_state;
   state_e           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic [CntW-1:0]  r_cnt;
   logic             r_br;
   logic             r_done;
   logic [WIDTH-1:0] r_diff;
   logic             r_bout;
   logic             w_d;
   logic             w_br_nxt;
   logic             w_ready;
   logic             w_accept;

`ifdef SUB_OVERFLOW_EN
   logic r_a_msb;
   logic r_b_msb;
   logic r_overflow;
`endif

   // Ready stays low through the done cycle so the next start lands after it.
   assign w_ready  = (r_state == StIdle) & ~r_done;
   assign w_accept = w_ready & i_start;

   full_subtractor u_cell (
      .i_a    (r_a[0]),
      .i_b    (r_b[0]),
      .i_bin  (r_br),
      .o_diff (w_d),
      .o_bout (w_br_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle:  if (w_accept) w_state_nxt = StRun;
         StRun:   if (r_cnt == LastCnt) w_state_nxt = StDone;
         StDone:  w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a    <= '0;
         r_b    <= '0;
         r_res  <= '0;
         r_cnt  <= '0;
         r_br   <= 1'b0;
         r_done <= 1'b0;
         r_diff <= '0;
         r_bout <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (w_accept) begin
                  r_a   <= i_a;
                  r_b   <= i_b;
                  r_br  <= i_bin;
                  r_cnt <= '0;
                  r_res <= '0;
               end
            end
            StRun: begin
               r_res <= {w_d, r_res[WIDTH-1:1]};
               r_a   <= {1'b0, r_a[WIDTH-1:1]};
               r_b   <= {1'b0, r_b[WIDTH-1:1]};
               r_br  <= w_br_nxt;
               r_cnt <= r_cnt + 1'b1;
            end
            StDone: begin
               r_diff <= r_res;
               r_bout <= r_br;
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef SUB_OVERFLOW_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_msb    <= 1'b0;
         r_b_msb    <= 1'b0;
         r_overflow <= 1'b0;
      end else if (w_accept) begin
         r_a_msb <= i_a[WIDTH-1];
         r_b_msb <= i_b[WIDTH-1];
      end else if (r_state == StDone) begin
         r_overflow <= (r_a_msb ^ r_b_msb) & (r_res[WIDTH-1] ^ r_a_msb);
      end
   end

   assign o_overflow = r_overflow;
`endif

   assign o_ready = w_ready;
   assign o_done  = r_done;
   assign o_diff  = r_diff;
   assign o_bout  = r_bout;

endmodule : serial_subtractor
